// File: rtl/apb_rr_master_if.sv
// APB bus bundle between apb_rr_master and the slave register blocks.
// The master drives the request phase; the slave returns PREADY/PSLVERR/PRDATA.
interface apb_rr_master_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                    PSELx;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [2:0]              PPROT;
  logic                    PREADY;
  logic                    PSLVERR;
  logic [DATA_WIDTH-1:0]   PRDATA;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/apb_rr_master.sv
// Round-robin APB master sharing one APB bus among NUM_REQ local requesters.
// Optional ACCESS-phase watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_rr_master #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  apb_rr_master_if.master                apb
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    SETUP  = 3'b010,
    ACCESS = 3'b100
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         cur_q, cur_d;
  logic [IW-1:0]         grant_idx;
  logic [IW-1:0]         cidx;
  int unsigned           cand;
  logic                  grant_found;
  logic                  grant;
  logic                  complete;
  logic                  timeout_hit;

  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] to_cnt_q;

  // Cleared during SETUP so every ACCESS phase starts counting from zero.
  always_ff @(posedge PCLK) begin
    if (!PRESETn)                               to_cnt_q <= '0;
    else if (state_q == SETUP)                  to_cnt_q <= '0;
    else if (state_q == ACCESS && !apb.PREADY)  to_cnt_q <= to_cnt_q + CW'(1);
  end

  assign timeout_hit = (state_q == ACCESS) && !apb.PREADY &&
                       (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: ACCESS waits on PREADY indefinitely.
  assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  assign complete = (state_q == ACCESS) && (apb.PREADY || timeout_hit);
  assign grant    = PRESETn && grant_found && ((state_q == IDLE) || complete);

  // First pending requester at or above ptr_q, wrapping at NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cidx        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cidx = IW'(cand);
      if (!grant_found && req_valid[cidx]) begin
        grant_found = 1'b1;
        grant_idx   = cidx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = grant ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (complete) state_d = grant ? SETUP : IDLE;
        else          state_d = ACCESS;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    cur_d     = cur_q;
    if (grant) begin
      pwrite_d = req_write[grant_idx];
      paddr_d  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      pwdata_d = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      pstrb_d  = req_write[grant_idx] ? '1 : '0;
      cur_d    = grant_idx;
    end
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    // A completion without PREADY is a watchdog abort: error, no data.
    if (complete) begin
      rsp_valid_d[cur_q] = 1'b1;
      rsp_err_d          = timeout_hit | apb.PSLVERR;
      rsp_rdata_d        = (pwrite_q || !apb.PREADY) ? '0 : apb.PRDATA;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      ptr_q       <= '0;
      cur_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cur_q       <= cur_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign apb.PSELx   = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PSTRB   = pstrb_q;
  assign apb.PPROT   = 3'b000;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench for apb_rr_master: randomized transfers against a
// transaction-timeline model of the round-robin APB master.
module tb_apb_rr_master;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned NR = 2;
  localparam int unsigned TO = 4;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic [NR-1:0]     req_valid, req_write, req_ready, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int ptr_m  = 0;

  apb_rr_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) apb ();

  apb_rr_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .apb(apb)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  // Round-robin rule: first pending requester at or after p, wrapping.
  function automatic int pick(input int p, input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int g);
    logic [NR-1:0] r;
    r = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  task automatic test_reset();
    PRESETn = 1'b0; req_valid = '1; req_write = '0; req_addr = '0; req_wdata = '0;
    apb.PREADY = 1'b0; apb.PSLVERR = 1'b0; apb.PRDATA = '0;
    repeat (3) @(negedge PCLK);
    #1;
    n_cmp++;
    if (req_ready !== '0) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 00", req_ready);
    end
    n_cmp++;
    if ({apb.PSELx, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB, apb.PPROT} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got sel=%b en=%b wr=%b addr=%h wd=%h strb=%b prot=%b expected all 0",
               apb.PSELx, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB, apb.PPROT);
    end
    n_cmp++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got v=%b d=%h e=%b expected 0", rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge PCLK);
    PRESETn = 1'b1; req_valid = '0;
    ptr_m = 0;
  endtask

  // Runs n transfers. b2b: next grant shares the previous completion cycle.
  // both: every requester keeps req_valid asserted at each arbitration point.
  task automatic test_seq(input string name, input int n, input bit b2b,
                          input int max_wait, input bit both);
    logic [AW-1:0]  a [NR];
    logic [DW-1:0]  wd [NR];
    logic [NR-1:0]  wr, pat;
    logic [DW/8-1:0] strb;
    logic [DW-1:0]  prd, p_prd;
    logic           perr, p_err, p_wr;
    int             g, p_g, w;
    bit             pend;
    pend = 1'b0; p_g = 0; p_prd = '0; p_err = 1'b0; p_wr = 1'b0;
    for (int t = 0; t < n; t++) begin
      pat  = both ? '1 : NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) begin
        a[i] = AW'($urandom); wd[i] = DW'($urandom); wr[i] = 1'($urandom_range(0, 1));
      end
      w    = $urandom_range(0, max_wait);
      prd  = DW'($urandom);
      perr = 1'($urandom_range(0, 1));

      // arbitration cycle
      @(negedge PCLK);
      req_valid = pat; req_write = wr;
      for (int i = 0; i < NR; i++) begin
        req_addr[i*AW +: AW] = a[i]; req_wdata[i*DW +: DW] = wd[i];
      end
      apb.PREADY  = pend ? 1'b1 : 1'($urandom_range(0, 1));
      apb.PRDATA  = pend ? p_prd : DW'($urandom);
      apb.PSLVERR = pend ? p_err : 1'b0;
      #1;
      g = pick(ptr_m, pat);
      ptr_m = (g + 1) % NR;
      strb = wr[g] ? '1 : '0;
      n_cmp++;
      if (req_ready !== onehot(g)) begin
        n_fail++; $display("FAIL %s_grant[%0d]: got %b expected %b", name, t, req_ready, onehot(g));
      end
      n_cmp++;
      if ({apb.PSELx, apb.PENABLE, rsp_valid} !== {pend, pend, {NR{1'b0}}}) begin
        n_fail++;
        $display("FAIL %s_arb_phase[%0d]: got sel=%b en=%b rv=%b expected sel=%b en=%b rv=0",
                 name, t, apb.PSELx, apb.PENABLE, rsp_valid, pend, pend);
      end

      // SETUP cycle; PREADY and req_valid are don't-care here
      @(negedge PCLK);
      req_valid = NR'($urandom_range(0, (1 << NR) - 1));
      apb.PREADY = 1'($urandom_range(0, 1)); apb.PRDATA = DW'($urandom);
      apb.PSLVERR = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (req_ready !== '0) begin
        n_fail++; $display("FAIL %s_setup_ready[%0d]: got %b expected 0", name, t, req_ready);
      end
      n_cmp++;
      if ({apb.PSELx, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB} !==
          {1'b1, 1'b0, wr[g], a[g], wd[g], strb}) begin
        n_fail++;
        $display("FAIL %s_setup_bus[%0d]: got sel=%b en=%b wr=%b addr=%h wd=%h strb=%b expected 1 0 %b %h %h %b",
                 name, t, apb.PSELx, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB,
                 wr[g], a[g], wd[g], strb);
      end
      n_cmp++;
      if (pend) begin
        if ({rsp_valid, rsp_rdata, rsp_err} !== {onehot(p_g), p_wr ? {DW{1'b0}} : p_prd, p_err}) begin
          n_fail++;
          $display("FAIL %s_b2b_rsp[%0d]: got v=%b d=%h e=%b expected v=%b d=%h e=%b", name, t,
                   rsp_valid, rsp_rdata, rsp_err, onehot(p_g), p_wr ? {DW{1'b0}} : p_prd, p_err);
        end
      end else if (rsp_valid !== '0) begin
        n_fail++; $display("FAIL %s_setup_rsp[%0d]: got %b expected 0", name, t, rsp_valid);
      end
      pend = 1'b0;

      // wait states
      for (int k = 0; k < w; k++) begin
        @(negedge PCLK);
        req_valid = NR'($urandom_range(0, (1 << NR) - 1));
        apb.PREADY = 1'b0; apb.PRDATA = DW'($urandom);
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, apb.PSELx, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB} !==
            {{NR{1'b0}}, {NR{1'b0}}, 1'b1, 1'b1, wr[g], a[g], wd[g], strb}) begin
          n_fail++;
          $display("FAIL %s_wait[%0d.%0d]: got rdy=%b rv=%b sel=%b en=%b wr=%b addr=%h wd=%h strb=%b expected stable ACCESS",
                   name, t, k, req_ready, rsp_valid, apb.PSELx, apb.PENABLE, apb.PWRITE,
                   apb.PADDR, apb.PWDATA, apb.PSTRB);
        end
      end

      if (b2b && t < n - 1) begin
        pend = 1'b1; p_g = g; p_prd = prd; p_err = perr; p_wr = wr[g];
      end else begin
        @(negedge PCLK);
        req_valid = '0; apb.PREADY = 1'b1; apb.PRDATA = prd; apb.PSLVERR = perr;
        #1;
        n_cmp++;
        if ({req_ready, apb.PSELx, apb.PENABLE} !== {{NR{1'b0}}, 1'b1, 1'b1}) begin
          n_fail++;
          $display("FAIL %s_complete[%0d]: got rdy=%b sel=%b en=%b expected 0 1 1",
                   name, t, req_ready, apb.PSELx, apb.PENABLE);
        end
        @(negedge PCLK);
        apb.PREADY = 1'($urandom_range(0, 1));
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_rdata, rsp_err} !== {onehot(g), wr[g] ? {DW{1'b0}} : prd, perr}) begin
          n_fail++;
          $display("FAIL %s_rsp[%0d]: got v=%b d=%h e=%b expected v=%b d=%h e=%b", name, t,
                   rsp_valid, rsp_rdata, rsp_err, onehot(g), wr[g] ? {DW{1'b0}} : prd, perr);
        end
        n_cmp++;
        if ({apb.PSELx, apb.PENABLE, apb.PADDR, apb.PWDATA} !== {1'b0, 1'b0, a[g], wd[g]}) begin
          n_fail++;
          $display("FAIL %s_idle_hold[%0d]: got sel=%b en=%b addr=%h wd=%h expected 0 0 %h %h",
                   name, t, apb.PSELx, apb.PENABLE, apb.PADDR, apb.PWDATA, a[g], wd[g]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] prd;
    prd = DW'($urandom);
    @(negedge PCLK);
    req_valid = 2'b01; req_write = '0; req_addr = NR*AW'($urandom); apb.PREADY = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_first_grant: got %b expected 01", req_ready);
    end
    @(negedge PCLK); req_valid = '0;
    @(negedge PCLK); #1;
    n_cmp++;
    if ({apb.PSELx, apb.PENABLE} !== 2'b11) begin
      n_fail++; $display("FAIL rstmid_access: got sel=%b en=%b expected 1 1", apb.PSELx, apb.PENABLE);
    end
    @(negedge PCLK);
    PRESETn = 1'b0; req_valid = '1;
    #1;
    n_cmp++;
    if (req_ready !== '0) begin
      n_fail++; $display("FAIL rstmid_ready_in_reset: got %b expected 00", req_ready);
    end
    @(negedge PCLK);
    PRESETn = 1'b1; req_valid = '0; apb.PREADY = 1'b1;
    #1;
    ptr_m = 0;
    n_cmp++;
    if ({apb.PSELx, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB,
         rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got sel=%b en=%b wr=%b addr=%h wd=%h strb=%b rv=%b d=%h e=%b expected all 0",
               apb.PSELx, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PWDATA, apb.PSTRB,
               rsp_valid, rsp_rdata, rsp_err);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK); #1;
      n_cmp++;
      if ({rsp_valid, apb.PSELx} !== '0) begin
        n_fail++; $display("FAIL rstmid_quiet[%0d]: got rv=%b sel=%b expected 0", k, rsp_valid, apb.PSELx);
      end
    end
    @(negedge PCLK);
    req_valid = '1; req_write = '0;
    #1;
    n_cmp++;
    if (req_ready !== onehot(pick(ptr_m, 2'b11))) begin
      n_fail++; $display("FAIL rstmid_regrant: got %b expected %b", req_ready, onehot(pick(ptr_m, 2'b11)));
    end
    ptr_m = 1;
    @(negedge PCLK); req_valid = '0; apb.PRDATA = prd; apb.PSLVERR = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK); #1;
    n_cmp++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== {2'b01, prd, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_rsp: got v=%b d=%h e=%b expected v=01 d=%h e=0", rsp_valid, rsp_rdata, rsp_err, prd);
    end
  endtask

  // Grant one transfer and stall the slave; returns the granted index.
  task automatic start_stalled(output int g);
    logic [NR-1:0] pat;
    pat = NR'($urandom_range(1, (1 << NR) - 1));
    @(negedge PCLK);
    req_valid = pat; req_write = NR'($urandom); apb.PREADY = 1'b0;
    #1;
    g = pick(ptr_m, pat);
    ptr_m = (g + 1) % NR;
    n_cmp++;
    if (req_ready !== onehot(g)) begin
      n_fail++; $display("FAIL stall_grant: got %b expected %b", req_ready, onehot(g));
    end
    @(negedge PCLK); req_valid = '0;
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int g;
    start_stalled(g);
    for (int k = 0; k < TO; k++) begin
      @(negedge PCLK); apb.PREADY = 1'b0; #1;
      n_cmp++;
      if ({apb.PSELx, apb.PENABLE, rsp_valid} !== {2'b11, {NR{1'b0}}}) begin
        n_fail++;
        $display("FAIL timeout_access[%0d]: got sel=%b en=%b rv=%b expected 1 1 0",
                 k, apb.PSELx, apb.PENABLE, rsp_valid);
      end
    end
    @(negedge PCLK); #1;
    n_cmp++;
    if ({apb.PSELx, apb.PENABLE, rsp_valid, rsp_rdata, rsp_err} !==
        {2'b00, onehot(g), {DW{1'b0}}, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_abort: got sel=%b en=%b v=%b d=%h e=%b expected 0 0 %b 00 1",
               apb.PSELx, apb.PENABLE, rsp_valid, rsp_rdata, rsp_err, onehot(g));
    end
  endtask
`else
  task automatic test_long_wait();
    int g;
    logic [DW-1:0] prd;
    logic          wr;
    prd = DW'($urandom);
    start_stalled(g);
    wr = apb.PWRITE;
    for (int k = 0; k < 120; k++) begin
      @(negedge PCLK); apb.PREADY = 1'b0; #1;
      n_cmp++;
      if ({apb.PSELx, apb.PENABLE, rsp_valid} !== {2'b11, {NR{1'b0}}}) begin
        n_fail++;
        $display("FAIL longwait_access[%0d]: got sel=%b en=%b rv=%b expected 1 1 0",
                 k, apb.PSELx, apb.PENABLE, rsp_valid);
      end
    end
    @(negedge PCLK); apb.PREADY = 1'b1; apb.PRDATA = prd; apb.PSLVERR = 1'b0;
    @(negedge PCLK); apb.PREADY = 1'b0; #1;
    n_cmp++;
    if ({apb.PSELx, rsp_valid, rsp_rdata, rsp_err} !==
        {1'b0, onehot(g), wr ? {DW{1'b0}} : prd, 1'b0}) begin
      n_fail++;
      $display("FAIL longwait_rsp: got sel=%b v=%b d=%h e=%b expected 0 %b %h 0",
               apb.PSELx, rsp_valid, rsp_rdata, rsp_err, onehot(g), wr ? {DW{1'b0}} : prd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_seq("fair", 6, 1'b1, 0, 1'b1);
    test_seq("single", 8, 1'b0, 3, 1'b0);
    test_seq("b2b", 12, 1'b1, 3, 1'b0);
    test_seq("b2b_both", 6, 1'b1, 2, 1'b1);
    test_reset_mid();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
